// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline constants and types for the MIPS stages.
// The MEM/WB bundle struct is shared with the memory stage.
package mips_pkg;

  localparam int ANCHO_DATO = 32;
  localparam int NUM_REG    = 32;
  localparam int ANCHO_DIR  = $clog2(NUM_REG);

  typedef logic [ANCHO_DIR-1:0] reg_dir_t;

  localparam reg_dir_t REG_CERO = 5'd0;

  // MEM/WB pipeline register contents
  typedef struct packed {
    logic [ANCHO_DATO-1:0] mem;  // load data
    logic [ANCHO_DATO-1:0] alu;  // ALU result
    reg_dir_t              rd;   // destination register
    logic                  m2r;  // 1: write back load data
    logic                  we;   // register write enable
  } mem_wb_t;

endpackage

// File: rtl/banco_registros.sv
// banco_registros: 32x32 GPR file, one write port, two combinational
// read ports. Register 0 is hardwired to zero.
// Optional macro ETAPA_WB_BYPASS_EN: a read that hits the register being
// written this cycle returns the write data (write-through).
module banco_registros
  import mips_pkg::*;
#(
  parameter int ANCHO_DATO = 32,
  parameter int NUM_REG    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(NUM_REG)-1:0] dir_escritura,
  input  logic [ANCHO_DATO-1:0]      dato_escritura,
  input  logic [$clog2(NUM_REG)-1:0] dir_lectura1,
  input  logic [$clog2(NUM_REG)-1:0] dir_lectura2,
  output logic [ANCHO_DATO-1:0]      dato_lectura1,
  output logic [ANCHO_DATO-1:0]      dato_lectura2
);

  logic [ANCHO_DATO-1:0] regs [NUM_REG];
  logic                  escribe;

  // writes to register 0 are dropped so it never holds a nonzero value
  assign escribe = we && (dir_escritura != REG_CERO);

  // array update; reset clears every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REG; i++) regs[i] <= '0;
    end else if (escribe) begin
      regs[dir_escritura] <= dato_escritura;
    end
  end

  // read ports: register 0 forced to zero, optional same-cycle bypass
  always_comb begin
    dato_lectura1 = (dir_lectura1 == REG_CERO) ? '0 : regs[dir_lectura1];
    dato_lectura2 = (dir_lectura2 == REG_CERO) ? '0 : regs[dir_lectura2];
`ifdef ETAPA_WB_BYPASS_EN
    if (escribe && (dir_lectura1 == dir_escritura)) dato_lectura1 = dato_escritura;
    if (escribe && (dir_lectura2 == dir_escritura)) dato_lectura2 = dato_escritura;
`endif
  end

endmodule

// File: rtl/etapa_wb.sv
// etapa_wb: MIPS write-back stage. MEM/WB register, MemToReg select,
// register file, forwarding outputs and committed-write counter.
// Optional macro ETAPA_WB_BYPASS_EN enables register-file write-through.
module etapa_wb #(
  parameter int ANCHO_DATO = 32,
  parameter int NUM_REG    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       congelar,
  input  logic                       vaciar,
  input  logic [ANCHO_DATO-1:0]      dato_memoria_out,
  input  logic [ANCHO_DATO-1:0]      alu_result_out,
  input  logic [$clog2(NUM_REG)-1:0] rd_out,
  input  logic                       mem_a_reg_out,
  input  logic                       reg_escribir_out,
  input  logic [$clog2(NUM_REG)-1:0] dir_lectura1,
  input  logic [$clog2(NUM_REG)-1:0] dir_lectura2,
  output logic [ANCHO_DATO-1:0]      dato_lectura1,
  output logic [ANCHO_DATO-1:0]      dato_lectura2,
  output logic [$clog2(NUM_REG)-1:0] rd_WB,
  output logic                       reg_escribir_WB,
  output logic [ANCHO_DATO-1:0]      dato_WB,
  output logic [31:0]                contador_escrituras
);
  import mips_pkg::*;

  mem_wb_t     q;
  logic        commit;
  logic [31:0] cnt_q;

  // MEM/WB register: reset > flush > stall > load. A flush only has to
  // kill the write; the data fields are don't-care and just load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (vaciar) begin
      q.mem <= dato_memoria_out;
      q.alu <= alu_result_out;
      q.m2r <= mem_a_reg_out;
      q.rd  <= REG_CERO;
      q.we  <= 1'b0;
    end else if (!congelar) begin
      q.mem <= dato_memoria_out;
      q.alu <= alu_result_out;
      q.rd  <= rd_out;
      q.m2r <= mem_a_reg_out;
      q.we  <= reg_escribir_out;
    end
  end

  assign dato_WB         = q.m2r ? q.mem : q.alu;
  assign rd_WB           = q.rd;
  assign reg_escribir_WB = q.we;

  // a stalled WB holds its instruction without writing, so it commits
  // exactly once when the stall releases
  assign commit = q.we && (q.rd != REG_CERO) && !congelar;

  // committed-write counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset)       cnt_q <= '0;
    else if (commit) cnt_q <= cnt_q + 32'd1;
  end

  assign contador_escrituras = cnt_q;

  banco_registros #(
    .ANCHO_DATO (ANCHO_DATO),
    .NUM_REG    (NUM_REG)
  ) u_banco (
    .clk            (clk),
    .reset          (reset),
    .we             (commit),
    .dir_escritura  (q.rd),
    .dato_escritura (dato_WB),
    .dir_lectura1   (dir_lectura1),
    .dir_lectura2   (dir_lectura2),
    .dato_lectura1  (dato_lectura1),
    .dato_lectura2  (dato_lectura2)
  );

endmodule

// File: tb/tb_etapa_wb.sv
module tb_etapa_wb;

  localparam int SEL_DATO = 0, SEL_RD = 1, SEL_WE = 2, SEL_CNT = 3,
                 SEL_L1 = 4, SEL_L2 = 5;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, congelar, vaciar;
  logic [31:0] dato_memoria_out, alu_result_out;
  logic [4:0]  rd_out, dir_lectura1, dir_lectura2;
  logic        mem_a_reg_out, reg_escribir_out;
  logic [31:0] dato_lectura1, dato_lectura2, dato_WB, contador_escrituras;
  logic [4:0]  rd_WB;
  logic        reg_escribir_WB;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  etapa_wb dut (
    .clk                 (clk),
    .reset               (reset),
    .congelar            (congelar),
    .vaciar              (vaciar),
    .dato_memoria_out    (dato_memoria_out),
    .alu_result_out      (alu_result_out),
    .rd_out              (rd_out),
    .mem_a_reg_out       (mem_a_reg_out),
    .reg_escribir_out    (reg_escribir_out),
    .dir_lectura1        (dir_lectura1),
    .dir_lectura2        (dir_lectura2),
    .dato_lectura1       (dato_lectura1),
    .dato_lectura2       (dato_lectura2),
    .rd_WB               (rd_WB),
    .reg_escribir_WB     (reg_escribir_WB),
    .dato_WB             (dato_WB),
    .contador_escrituras (contador_escrituras)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(int sel);
    case (sel)
      SEL_DATO: return dato_WB;
      SEL_RD:   return {27'd0, rd_WB};
      SEL_WE:   return {31'd0, reg_escribir_WB};
      SEL_CNT:  return contador_escrituras;
      SEL_L1:   return dato_lectura1;
      default:  return dato_lectura2;
    endcase
  endfunction

  function automatic void expect_at(int c, int sel, logic [31:0] v, string n);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = v; e.name = n;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] got;
        got = sample(sb[i].sel);
        n_checks++;
        if (got === sb[i].val) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      sb[i].name, got, sb[i].val, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_in();
    congelar = 0; vaciar = 0;
    dato_memoria_out = '0; alu_result_out = '0; rd_out = '0;
    mem_a_reg_out = 0; reg_escribir_out = 0;
  endtask

  task automatic issue(logic [4:0] rd, logic [31:0] alu, logic [31:0] mem, logic m2r);
    rd_out = rd; alu_result_out = alu; dato_memoria_out = mem;
    mem_a_reg_out = m2r; reg_escribir_out = 1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_in();
    dir_lectura1 = '0; dir_lectura2 = '0;
    reset = 1;
    tick(); tick();
    reset = 0;

    n_checks++;
    if (dato_WB === 32'h0) n_pass++;
    else $display("FAIL rst_dato_direct: got %h expected %h", dato_WB, 32'h0);
    n_checks++;
    if (rd_WB === 5'd0) n_pass++;
    else $display("FAIL rst_rd_direct: got %h expected %h", rd_WB, 5'd0);
    n_checks++;
    if (reg_escribir_WB === 1'b0) n_pass++;
    else $display("FAIL rst_we_direct: got %h expected %h", reg_escribir_WB, 1'b0);
    n_checks++;
    if (contador_escrituras === 32'h0) n_pass++;
    else $display("FAIL rst_cnt_direct: got %h expected %h", contador_escrituras, 32'h0);

    expect_at(cyc, SEL_DATO, 32'h0, "rst_dato_wb");
    expect_at(cyc, SEL_RD,   32'h0, "rst_rd_wb");
    expect_at(cyc, SEL_WE,   32'h0, "rst_we_wb");
    expect_at(cyc, SEL_CNT,  32'h0, "rst_cnt");
    for (int i = 1; i < 32; i++) begin
      dir_lectura1 = 5'(i);
      dir_lectura2 = 5'(32 - i);
      expect_at(cyc, SEL_L1, 32'h0, "rst_read1");
      expect_at(cyc, SEL_L2, 32'h0, "rst_read2");
      tick();
    end

    issue(5'd5, 32'h0000_1234, 32'h0000_9999, 1'b0);
    expect_at(cyc + 1, SEL_DATO, 32'h1234, "alu_dato_wb");
    expect_at(cyc + 1, SEL_RD,   32'd5,    "alu_rd_wb");
    expect_at(cyc + 1, SEL_WE,   32'd1,    "alu_we_wb");
    tick();
    clear_in();
    dir_lectura1 = 5'd5;
    expect_at(cyc + 1, SEL_L1,  32'h1234, "alu_read_r5");
    expect_at(cyc + 1, SEL_CNT, 32'd1,    "alu_cnt");
    tick(); tick();

    issue(5'd0, 32'h0000_5555, 32'hDEAD_BEEF, 1'b1);
    expect_at(cyc + 1, SEL_DATO, 32'hDEAD_BEEF, "ld_dato_wb");
    expect_at(cyc + 1, SEL_RD,   32'd0,         "ld_rd_wb");
    tick();
    clear_in();
    dir_lectura1 = 5'd0;
    expect_at(cyc + 1, SEL_L1,  32'h0, "ld_read_r0");
    expect_at(cyc + 1, SEL_CNT, 32'd1, "ld_cnt_unchanged");
    tick(); tick();

    issue(5'd7, 32'h0000_0077, 32'h0, 1'b0);
    tick();
    clear_in();
    congelar = 1;
    dir_lectura1 = 5'd7;
    for (int k = 0; k < 3; k++) begin
      expect_at(cyc, SEL_L1,   32'h0,  "stall_r7_old");
      expect_at(cyc, SEL_CNT,  32'd1,  "stall_cnt");
      expect_at(cyc, SEL_RD,   32'd7,  "stall_rd_hold");
      expect_at(cyc, SEL_DATO, 32'h77, "stall_dato_hold");
      tick();
    end
    congelar = 0;
    tick();
    n_checks++;
    if (contador_escrituras === 32'd2) n_pass++;
    else $display("FAIL stall_cnt_direct: got %h expected %h", contador_escrituras, 32'd2);
    n_checks++;
    if (dato_lectura1 === 32'h77) n_pass++;
    else $display("FAIL stall_r7_direct: got %h expected %h", dato_lectura1, 32'h77);
    expect_at(cyc,     SEL_L1,  32'h77, "stall_r7_new");
    expect_at(cyc,     SEL_CNT, 32'd2,  "stall_cnt_once");
    expect_at(cyc + 1, SEL_CNT, 32'd2,  "stall_cnt_stable");
    tick(); tick();

    issue(5'd3, 32'h0000_0033, 32'h0, 1'b0);
    tick();
    issue(5'd4, 32'h0000_0044, 32'h0, 1'b0);
    vaciar = 1; congelar = 1;
    expect_at(cyc + 1, SEL_WE, 32'd0, "flush_we_wb");
    expect_at(cyc + 1, SEL_RD, 32'd0, "flush_rd_wb");
    tick();
    clear_in();
    dir_lectura1 = 5'd3;
    dir_lectura2 = 5'd4;
    expect_at(cyc + 1, SEL_L1,  32'h0, "flush_r3_unwritten");
    expect_at(cyc + 1, SEL_L2,  32'h0, "flush_r4_unwritten");
    expect_at(cyc + 1, SEL_CNT, 32'd2, "flush_cnt");
    tick(); tick();

    issue(5'd9, 32'h0000_ABCD, 32'h0, 1'b0);
    tick();
    clear_in();
    dir_lectura1 = 5'd9;
`ifdef ETAPA_WB_BYPASS_EN
    expect_at(cyc, SEL_L1, 32'hABCD, "bypass_same_cycle");
`else
    expect_at(cyc, SEL_L1, 32'h0,    "nobypass_same_cycle");
`endif
    expect_at(cyc + 1, SEL_L1,  32'hABCD, "bypass_next_cycle");
    expect_at(cyc + 1, SEL_CNT, 32'd3,    "bypass_cnt");
    tick(); tick();

    issue(5'd10, 32'h0000_AAAA, 32'h0, 1'b0);
    tick();
    clear_in();
    reset = 1;
    tick();
    reset = 0;
    dir_lectura1 = 5'd10;
    dir_lectura2 = 5'd9;
    expect_at(cyc, SEL_L1,  32'h0, "rstmid_r10");
    expect_at(cyc, SEL_L2,  32'h0, "rstmid_r9_cleared");
    expect_at(cyc, SEL_CNT, 32'h0, "rstmid_cnt");
    expect_at(cyc, SEL_WE,  32'h0, "rstmid_we_wb");
    tick();

    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    issue(5'd11, 32'h0000_0011, 32'h0, 1'b0);
    expect_at(cyc, SEL_CNT, 32'hFFFF_FFFF, "wrap_preload");
    tick();
    clear_in();
    dir_lectura1 = 5'd11;
    expect_at(cyc + 1, SEL_CNT, 32'h0,  "wrap_cnt");
    expect_at(cyc + 1, SEL_L1,  32'h11, "wrap_r11");
    tick(); tick(); tick();

    foreach (sb[i]) begin
      n_checks++;
      $display("FAIL %s: got none expected %h (never sampled)", sb[i].name, sb[i].val);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/etapa_wb.md
# etapa_wb

Write-back stage of the five-stage MIPS pipeline, directly downstream of the memory stage. It contains the MEM/WB pipeline register, the MemToReg result select, and the 32×32 general-purpose register file that the decode stage reads. It also exports write-back forwarding signals and a committed-write counter.

## Interface
Parameters:
- `ANCHO_DATO`, 32: data and register width.
- `NUM_REG`, 32: number of registers (address width 5).

Ports:
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous, active-high.
- `congelar`, in, 1: stall; the MEM/WB register holds its contents.
- `vaciar`, in, 1: flush; the MEM/WB register loads a bubble.
- `dato_memoria_out`, in, 32: load data from the memory stage.
- `alu_result_out`, in, 32: ALU result from the memory stage.
- `rd_out`, in, 5: destination register from the memory stage.
- `mem_a_reg_out`, in, 1: MemToReg; 1 selects load data.
- `reg_escribir_out`, in, 1: RegWrite from the memory stage.
- `dir_lectura1`, in, 5: decode read address for port 1.
- `dir_lectura2`, in, 5: decode read address for port 2.
- `dato_lectura1`, out, 32: read data for port 1 (combinational).
- `dato_lectura2`, out, 32: read data for port 2 (combinational).
- `rd_WB`, out, 5: registered destination register, for the forwarding unit.
- `reg_escribir_WB`, out, 1: registered RegWrite, for the forwarding unit.
- `dato_WB`, out, 32: selected write-back value, for the forwarding unit.
- `contador_escrituras`, out, 32: count of committed register writes.

## Operation
- MEM/WB register fields: `mem_q`, `alu_q`, `rd_q`, `m2r_q`, `we_q`.
- Priority on each rising edge is `reset` > `vaciar` > `congelar` > normal load.
  - `reset`: all fields go to 0, every register-file entry goes to 0, and `contador_escrituras` goes to 0.
  - `vaciar`: `we_q` = 0 and `rd_q` = 0. The data fields load don't-care values, which the bench must not check.
  - `congelar` (without `vaciar`): all fields hold.
  - Normal: all fields load from the inputs.
- Write-back select: `dato_WB` = `m2r_q` ? `mem_q` : `alu_q`.
- Output mapping: `rd_WB` = `rd_q` and `reg_escribir_WB` = `we_q`.
- Commit condition: `commit` = `we_q` & (`rd_q` != 0) & ~`congelar`.
  - Under stall, WB does not commit, so the held instruction commits exactly once, after the stall releases.
- On `commit` at a rising edge: reg[`rd_q`] takes `dato_WB`, and `contador_escrituras` increments by 1. The counter wraps from 0xFFFFFFFF to 0.
- Register 0 always reads 0. A write to register 0 is discarded and does not count as a commit.
- Read ports are combinational from the array, subject to the bypass described under Configuration.
- A mid-operation `reset` discards any pending write in that same cycle: reset wins over commit.

## Timing
- Latency from the memory-stage inputs to the `dato_WB`/`rd_WB` outputs is one cycle.
- Latency from the inputs to the register-file update is two edges. The update is visible on the read ports after the second edge, or in the same cycle as that commit when bypass is enabled.
- Reset values of the outputs:
  - `rd_WB` = 0, `reg_escribir_WB` = 0, `dato_WB` = 0, `contador_escrituras` = 0.
  - `dato_lectura1` and `dato_lectura2` are 0 for every address.
- There is no handshake. `congelar` and `vaciar` are level signals sampled at each edge.

## Configuration
- Macro `ETAPA_WB_BYPASS_EN`.
  - Defined: when `commit` is true and `dir_lecturaN` == `rd_q`, `dato_lecturaN` = `dato_WB` (write-through within the same cycle). This resolves the WB→ID hazard without a split-cycle register file.
  - Undefined: reads return array contents only, so the new value appears the cycle after the commit. The hazard unit must then insert one extra stall.

## Structure
- Shared package `mips_pkg` holds:
  - `ANCHO_DATO` and `NUM_REG`.
  - Register-address type `reg_dir_t` (5 bits).
  - Constant `REG_CERO` = 5'd0.
  - A struct for the MEM/WB bundle (`mem_wb_t`: mem, alu, rd, m2r, we). The memory stage reuses this struct.
- One sub-module, `banco_registros`, contains:
  - the array, the write port, the two read ports, the register-0 rule, and the optional bypass.
- The MEM/WB register, the select, and the counter stay in `etapa_wb`.

## Test plan
- Reset check: assert `reset` for 2 cycles, then release. Required:
  - all outputs are 0 and `contador_escrituras` = 0;
  - reads of addresses 1–31 return 0.
- ALU write: present `alu_result_out`=0x0000_1234, `rd_out`=5, `mem_a_reg_out`=0, `reg_escribir_out`=1 for one cycle. Required:
  - next cycle, `dato_WB`=0x1234 and `rd_WB`=5;
  - after the following edge, a read of address 5 returns 0x1234 and the counter = 1.
- Load write with register 0: present `dato_memoria_out`=0xDEAD_BEEF, `mem_a_reg_out`=1, `rd_out`=0, `reg_escribir_out`=1. Required:
  - `dato_WB`=0xDEADBEEF;
  - a read of address 0 returns 0;
  - the counter is unchanged.
- Stall and flush:
  - Hold `congelar` for 3 cycles with a pending write to register 7 = 0x77. Required: register 7 does not change until release, then commits once and the counter increments by 1.
  - Assert `vaciar` and `congelar` in the same cycle. Required: a bubble loads (`reg_escribir_WB`=0).
- Bypass: during the commit cycle of register 9 = 0xABCD, set `dir_lectura1`=9. Required:
  - with `ETAPA_WB_BYPASS_EN`, `dato_lectura1`=0xABCD in that cycle;
  - without it, `dato_lectura1` shows the old value in that cycle and 0xABCD the next cycle.
- Reset mid-write and counter wrap:
  - Assert `reset` in a commit cycle. Required: the register stays 0 and the counter is 0.
  - Force the counter to 0xFFFFFFFF, then commit once. Required: the counter reads 0.
